// File: rtl/caravel_flash_console.sv
// caravel_flash_console
//   Boot-time console streamer. After reset it wakes the SPI boot flash,
//   issues a single READ (0x03) at START_ADDR and streams bytes onto
//   mprj_io[15:8], strobing gpio once per byte, until EOT_CHAR is seen or
//   MAX_BYTES bytes have gone out. CS stays low across the whole stream so
//   the flash auto-increments its address.
// Ports
//   clock      : sole clock, rising edge
//   resetb     : asynchronous active-low reset
//   gpio       : byte strobe, active high, registered
//   mprj_io    : [15:8] console byte (always driven), all other bits high-Z
//   flash_csb  : SPI chip select, active low
//   flash_clk  : SPI clock, mode 0
//   flash_io0  : MOSI
//   flash_io1  : MISO
module caravel_flash_console #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter logic [7:0]  EOT_CHAR   = 8'h04,
  parameter int unsigned MAX_BYTES  = 65536,
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned PULSE_CYC  = 4
) (
  input  logic        clock,
  input  logic        resetb,
  output logic        gpio,
  inout  wire  [37:0] mprj_io,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam bit          FAST       = (CLK_DIV == 1);
  localparam logic [15:0] WAIT_LAST  = 16'd15;
  localparam logic [15:0] GAP_LAST   = 16'(CLK_DIV + 4 - 1);
  localparam logic [15:0] GPIO_ON    = 16'(SETUP_CYC - 1);
  localparam logic [15:0] GPIO_OFF   = 16'(SETUP_CYC + PULSE_CYC - 1);
  localparam logic [15:0] EMIT_LAST  = 16'(2 * SETUP_CYC + PULSE_CYC - 1);
  localparam logic [31:0] COUNT_LAST = 32'(MAX_BYTES - 1);
  localparam logic [31:0] WAKE_WORD  = {8'hAB, 24'h000000};
  localparam logic [31:0] CMD_WORD   = {8'h03, START_ADDR};

  typedef enum logic [2:0] {
    S_WAIT, S_WAKE, S_GAP, S_CMD, S_READ, S_EMIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;      // generic cycle counter (WAIT/GAP/EMIT)
  logic [15:0] div_q, div_d;      // position inside one flash_clk half
  logic [5:0]  nbits_q, nbits_d;  // bits remaining in current SPI frame
  logic [31:0] sh_q, sh_d;        // outgoing bits, MSB first
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  pad_q, pad_d;
  logic [31:0] count_q, count_d;  // bytes emitted so far minus one
  logic        csb_q, csb_d;
  logic        fclk_q, fclk_d;
  logic        io0_q, io0_d;
  logic        gpio_q, gpio_d;
  logic        frame_end;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      div_q   <= '0;
      nbits_q <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      pad_q   <= '0;
      count_q <= '0;
      csb_q   <= 1'b1;
      fclk_q  <= 1'b0;
      io0_q   <= 1'b0;
      gpio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      pad_q   <= pad_d;
      count_q <= count_d;
      csb_q   <= csb_d;
      fclk_q  <= fclk_d;
      io0_q   <= io0_d;
      gpio_q  <= gpio_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    nbits_d   = nbits_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    pad_d     = pad_q;
    count_d   = count_q;
    csb_d     = csb_q;
    fclk_d    = fclk_q;
    io0_d     = io0_q;
    gpio_d    = gpio_q;
    frame_end = 1'b0;

    // Shared SPI bit engine: each bit is a low half then a high half.
    // MISO is captured on the edge that raises flash_clk; the frame ends
    // on the falling edge after the last bit.
    if (state_q inside {S_WAKE, S_CMD, S_READ}) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (!fclk_q) begin
          fclk_d = 1'b1;
          rx_d   = {rx_q[6:0], flash_io1};
        end else begin
          fclk_d    = 1'b0;
          sh_d      = {sh_q[30:0], 1'b0};
          nbits_d   = nbits_q - 6'd1;
          // With a one-cycle half there is no later low cycle to use.
          if (FAST) io0_d = sh_q[30];
          frame_end = (nbits_q == 6'd1);
        end
      end else begin
        div_d = div_q + 16'd1;
        // MOSI moves one clock after the fall, well clear of the next rise.
        if (!FAST && !fclk_q && div_q == 16'd0) io0_d = sh_q[31];
      end
    end

    case (state_q)
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_WAKE;
          csb_d   = 1'b0;
          sh_d    = WAKE_WORD;
          io0_d   = WAKE_WORD[31];
          nbits_d = 6'd8;
          div_d   = '0;
          fclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAKE: begin
        if (frame_end) begin
          state_d = S_GAP;
          cnt_d   = '0;
          io0_d   = 1'b0;
        end
      end
      S_GAP: begin
        // CS stays low for one half-period after the last fall, then high
        // for four cycles before the READ command frame.
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == DIV_LAST) csb_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d = S_CMD;
          csb_d   = 1'b0;
          sh_d    = CMD_WORD;
          io0_d   = CMD_WORD[31];
          nbits_d = 6'd32;
          div_d   = '0;
          fclk_d  = 1'b0;
        end
      end
      S_CMD: begin
        if (frame_end) begin
          state_d = S_READ;
          sh_d    = '0;
          io0_d   = 1'b0;
          nbits_d = 6'd8;
        end
      end
      S_READ: begin
        if (frame_end) begin
          state_d = S_EMIT;
          pad_d   = rx_q;
          cnt_d   = '0;
        end
      end
      S_EMIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GPIO_ON)  gpio_d = 1'b1;
        if (cnt_q == GPIO_OFF) gpio_d = 1'b0;
        if (cnt_q == EMIT_LAST) begin
          if (pad_q == EOT_CHAR || count_q == COUNT_LAST) begin
            state_d = S_DONE;
            csb_d   = 1'b1;
          end else begin
            state_d = S_READ;
            count_d = count_q + 32'd1;
            nbits_d = 6'd8;
            div_d   = '0;
            fclk_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        csb_d  = 1'b1;
        fclk_d = 1'b0;
        gpio_d = 1'b0;
      end
      default: state_d = S_WAIT;
    endcase
  end

  assign gpio      = gpio_q;
  assign flash_csb = csb_q;
  assign flash_clk = fclk_q;
  assign flash_io0 = io0_q;
  assign mprj_io   = {22'bz, pad_q, 8'bz};

endmodule

// File: tb/tb_caravel_flash_console.sv
module tb_caravel_flash_console;

  localparam int          CLK_DIV    = 2;
  localparam logic [23:0] START_ADDR = 24'h000100;
  localparam logic [7:0]  EOT_CHAR   = 8'h04;
  localparam int          MAX_BYTES  = 6;
  localparam int          SETUP_CYC  = 3;
  localparam int          PULSE_CYC  = 5;
  localparam int          BYTE_CYC   = 16 * CLK_DIV + 2 * SETUP_CYC + PULSE_CYC;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        gpio, flash_csb, flash_clk, flash_io0;
  logic        flash_io1 = 1'b0;
  wire  [37:0] mprj_io;
  wire  [7:0]  pads = mprj_io[15:8];

  caravel_flash_console #(
    .CLK_DIV(CLK_DIV), .START_ADDR(START_ADDR), .EOT_CHAR(EOT_CHAR),
    .MAX_BYTES(MAX_BYTES), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC)
  ) dut (
    .clock(clock), .resetb(resetb), .gpio(gpio), .mprj_io(mprj_io),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Flash contents and the byte stream they imply.
  logic [7:0] mem [0:511];
  logic [7:0] exp_q [$];

  task automatic build_expected();
    int a;
    a = int'(START_ADDR);
    exp_q.delete();
    for (int n = 0; n < MAX_BYTES; n++) begin
      exp_q.push_back(mem[a % 512]);
      if (mem[a % 512] == EOT_CHAR) break;
      a++;
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 512; i++) mem[i] = v;
  endtask

  // Monitor state: strobe scoreboard plus a behavioural SPI flash.
  int         pulse_idx, since_pad, since_fall, since_rise, rise_gap;
  int         since_ffall, since_cfall, csb_high;
  logic       prev_gpio, prev_csb, prev_fclk, prev_io0;
  logic [7:0] prev_pad, rise_pad, fcur;
  bit         done_seen, reading;
  int         frame_idx, fbits, rd_bit;
  logic [7:0] fbytes [$];
  logic [8:0] rd_addr;
  logic [23:0] faddr;

  always @(negedge clock) begin
    if (!resetb) begin
      chk("reset_pads", {24'd0, pads}, 32'h0);
      chk("reset_outs", {28'd0, gpio, flash_csb, flash_clk, flash_io0}, 32'h4);
      pulse_idx = 0; since_pad = 1000; since_fall = 1000; since_rise = 0;
      rise_gap = 0; since_ffall = 1000; since_cfall = 0; csb_high = 0;
      prev_gpio = 0; prev_csb = 1; prev_fclk = 0; prev_io0 = 0;
      prev_pad = 8'h00; rise_pad = 8'h00; done_seen = 0; reading = 0;
      frame_idx = 0; fbits = 0; fbytes.delete(); flash_io1 = 1'b0;
    end else begin
      rise_gap++; since_rise++; since_fall++; since_pad++;
      since_ffall++; since_cfall++; csb_high++;

      // Console pads: only ever move to the next expected byte, and only
      // while gpio is low and away from its falling edge.
      if (pads !== prev_pad) begin
        chk("pad_stable_while_high", {31'd0, prev_gpio | gpio}, 32'd0);
        chk("pad_hold_after_fall", {31'd0, since_fall >= SETUP_CYC}, 32'd1);
        if (pulse_idx < exp_q.size()) chk("pad_next_value", {24'd0, pads}, {24'd0, exp_q[pulse_idx]});
        else chk("pad_change_after_done", {24'd0, pads}, {24'd0, prev_pad});
        since_pad = 0;
      end
      if (gpio && !prev_gpio) begin
        $display("strobe %0d pads=%02h", pulse_idx, pads);
        if (pulse_idx < exp_q.size()) begin
          chk("strobe_data", {24'd0, pads}, {24'd0, exp_q[pulse_idx]});
          chk("setup_before_rise", {31'd0, since_pad >= SETUP_CYC}, 32'd1);
          if (pulse_idx > 0) chk("byte_period", rise_gap, BYTE_CYC);
        end else begin
          chk("extra_strobe", pulse_idx, exp_q.size());
        end
        rise_pad = pads; rise_gap = 0; since_rise = 0;
      end
      if (!gpio && prev_gpio) begin
        chk("pad_at_fall", {24'd0, pads}, {24'd0, rise_pad});
        chk("pulse_width", since_rise, PULSE_CYC);
        since_fall = 0;
        pulse_idx++;
        if (pulse_idx == exp_q.size()) done_seen = 1;
      end
      if (done_seen && since_fall > SETUP_CYC) begin
        chk("done_quiet", {29'd0, gpio, flash_csb, flash_clk}, 32'h2);
        chk("done_pads", {24'd0, pads}, {24'd0, exp_q[exp_q.size() - 1]});
      end

      // SPI bus rules.
      if (flash_csb) chk("clk_idle_low", {31'd0, flash_clk}, 32'd0);
      if (flash_clk) chk("io0_stable_high", {31'd0, flash_io0}, {31'd0, prev_io0});
      if (!flash_clk && prev_fclk) since_ffall = 0;
      if (flash_csb && !prev_csb) begin
        chk("csb_rise_after_clk", {31'd0, since_ffall >= CLK_DIV}, 32'd1);
        if (frame_idx == 1) begin
          chk("wake_frame_len", fbytes.size(), 1);
          if (fbytes.size() >= 1) chk("wake_opcode", {24'd0, fbytes[0]}, 32'hAB);
        end
        csb_high = 0;
      end
      if (!flash_csb && prev_csb) begin
        frame_idx++;
        if (frame_idx == 2) chk("wake_gap", {31'd0, csb_high >= 4}, 32'd1);
        fbits = 0; fbytes.delete(); reading = 0; since_cfall = 0;
      end
      if (!flash_csb && flash_clk && !prev_fclk && !reading) begin
        if (fbits == 0) chk("csb_lead", {31'd0, since_cfall >= CLK_DIV}, 32'd1);
        fcur = {fcur[6:0], flash_io0};
        fbits++;
        if (fbits % 8 == 0) fbytes.push_back(fcur);
        if (fbits == 32 && fbytes[0] == 8'h03) begin
          faddr = {fbytes[1], fbytes[2], fbytes[3]};
          if (frame_idx == 2) begin
            chk("cmd_opcode", {24'd0, fbytes[0]}, 32'h03);
            chk("addr_bytes", {8'd0, faddr}, 32'h000100);
          end
          reading = 1; rd_addr = faddr[8:0]; rd_bit = 7;
        end
      end
      if (!flash_csb && !flash_clk && prev_fclk && reading) begin
        flash_io1 = mem[rd_addr][rd_bit];
        if (rd_bit == 0) begin rd_bit = 7; rd_addr++; end
        else rd_bit--;
      end

      prev_gpio = gpio; prev_pad = pads; prev_csb = flash_csb;
      prev_fclk = flash_clk; prev_io0 = flash_io0;
    end
  end

  always @(posedge gpio) begin
    #1;
    if (pulse_idx < exp_q.size()) chk("pad_rise_1ns", {24'd0, pads}, {24'd0, exp_q[pulse_idx]});
  end

  task automatic run_stream(input string tag);
    int cyc;
    cyc = 0;
    build_expected();
    @(posedge clock); #2 resetb = 1'b1;
    while (!done_seen && cyc < 4000) begin @(negedge clock); cyc++; end
    chk("done_reached", {31'd0, done_seen}, 32'd1);
    repeat (300) @(negedge clock);
    chk("pulse_count", pulse_idx, exp_q.size());
    chk("frame_count", frame_idx, 2);
    $display("run %s: strobes %0d expected %0d", tag, pulse_idx, exp_q.size());
    @(posedge clock); #2 resetb = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic load_text();
    fill(8'hFF);
    mem[256] = 8'h4F; mem[257] = 8'h4B; mem[258] = 8'h0A; mem[259] = 8'h04;
  endtask

  initial begin
    int cyc;
    logic [7:0] v;
    int pos;
    #1 resetb = 1'b0;
    repeat (3) @(posedge clock);

    load_text();
    build_expected();
    chk("model_text_len", exp_q.size(), 4);
    chk("model_text_first", {24'd0, exp_q[0]}, 32'h4F);
    chk("model_text_last", {24'd0, exp_q[3]}, 32'h04);
    run_stream("ok_text");

    fill(8'hFF); mem[256] = 8'h41; mem[257] = 8'h04;
    build_expected();
    chk("model_a_len", exp_q.size(), 2);
    run_stream("a_eot");

    fill(8'h55);
    build_expected();
    chk("model_cap_len", exp_q.size(), 6);
    run_stream("cap_55");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 512; i++) begin
        v = 8'($urandom_range(255, 0));
        mem[i] = (v == EOT_CHAR) ? 8'h05 : v;
      end
      pos = int'($urandom_range(7, 0));
      mem[256 + pos] = EOT_CHAR;
      run_stream("random");
    end

    // Reset while the second byte is being strobed, then replay.
    load_text();
    build_expected();
    @(posedge clock); #2 resetb = 1'b1;
    cyc = 0;
    while (!(gpio && pulse_idx == 1) && cyc < 4000) begin @(negedge clock); cyc++; end
    chk("second_strobe_reached", {31'd0, gpio}, 32'd1);
    #2 resetb = 1'b0;
    #1;
    chk("async_reset_outs", {29'd0, gpio, flash_csb, flash_clk}, 32'h2);
    chk("async_reset_pads", {24'd0, pads}, 32'h0);
    repeat (3) @(posedge clock);
    run_stream("replay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
